// File: rtl/btn_intr_debounce.sv
// Pushbutton conditioner: two-flop synchronizer, press/release debounce FSM,
// one fixed-width interrupt pulse per accepted press, and a wrapping press counter.
module btn_intr_debounce #(
  parameter int DB_COUNT  = 10000,
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN,
  output logic             INTR,
  output logic             BTN_DB,
  output logic [CNT_W-1:0] PRESS_CNT
);

  localparam int MAX_LEN = (DB_COUNT > PULSE_LEN) ? DB_COUNT : PULSE_LEN;
  localparam int CW      = $clog2(MAX_LEN) + 1;
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_COUNT - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    PULSE,
    HELD,
    DB_RELEASE
  } state_t;

  logic             s1_q, s2_q;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic             intr_q, db_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= BTN;
      s2_q <= s1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = press_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = DB_PRESS;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      DB_PRESS: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
          press_d = press_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // The button level is deliberately ignored so the pulse is never cut short.
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!s2_q) begin
          state_d = DB_RELEASE;
          cnt_d   = CW'(1);
        end
      end
      DB_RELEASE: begin
        if (s2_q) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet track the state exactly.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= '0;
      intr_q  <= 1'b0;
      db_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      intr_q  <= (state_d == PULSE);
      db_q    <= (state_d == PULSE) || (state_d == HELD) || (state_d == DB_RELEASE);
    end
  end

  assign INTR      = intr_q;
  assign BTN_DB    = db_q;
  assign PRESS_CNT = press_q;

endmodule

// File: tb/tb_btn_intr_debounce.sv
// Directed bench for btn_intr_debounce with DB_COUNT=4, PULSE_LEN=3, CNT_W=8;
// edge numbers below count from the first rising edge that samples the new BTN level.
module tb_btn_intr_debounce;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN = 1'b0;
  logic       INTR;
  logic       BTN_DB;
  logic [7:0] PRESS_CNT;

  int checkCount = 0;
  int passCount  = 0;
  int intrRises  = 0;
  logic intrPrev = 1'b0;

  btn_intr_debounce #(.DB_COUNT(4), .PULSE_LEN(3), .CNT_W(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN      (BTN),
    .INTR     (INTR),
    .BTN_DB   (BTN_DB),
    .PRESS_CNT(PRESS_CNT)
  );

  always #5 CLK = ~CLK;

  // Pulses are counted on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    if (INTR && !intrPrev) intrRises = intrRises + 1;
    intrPrev = INTR;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    BTN = level;
    tick(cycles);
  endtask

  task automatic doReset();
    BTN = 1'b0;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  initial begin
    int rises0;

    tick(2);
    checkOutput("reset_intr", {31'd0, INTR}, 32'd0);
    checkOutput("reset_db", {31'd0, BTN_DB}, 32'd0);
    checkOutput("reset_cnt", {24'd0, PRESS_CNT}, 32'd0);
    RST = 1'b0;
    tick(2);

    // Clean press held 40 cycles.
    rises0 = intrRises;
    applyStimulus(1'b1, 5);
    checkOutput("clean_intr_e5", {31'd0, INTR}, 32'd0);
    checkOutput("clean_db_e5", {31'd0, BTN_DB}, 32'd0);
    checkOutput("clean_cnt_e5", {24'd0, PRESS_CNT}, 32'd0);
    tick(1);
    checkOutput("clean_intr_e6", {31'd0, INTR}, 32'd1);
    checkOutput("clean_db_e6", {31'd0, BTN_DB}, 32'd1);
    checkOutput("clean_cnt_e6", {24'd0, PRESS_CNT}, 32'd1);
    tick(2);
    checkOutput("clean_intr_e8", {31'd0, INTR}, 32'd1);
    tick(1);
    checkOutput("clean_intr_e9", {31'd0, INTR}, 32'd0);
    checkOutput("clean_db_e9", {31'd0, BTN_DB}, 32'd1);
    tick(31);
    checkOutput("clean_rises", intrRises - rises0, 32'd1);
    applyStimulus(1'b0, 5);
    checkOutput("release_db_e5", {31'd0, BTN_DB}, 32'd1);
    tick(1);
    checkOutput("release_db_e6", {31'd0, BTN_DB}, 32'd0);
    tick(4);

    // Bounce: two-cycle high phases never reach DB_COUNT samples.
    doReset();
    rises0 = intrRises;
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 20);
    checkOutput("bounce_rises", intrRises - rises0, 32'd0);
    checkOutput("bounce_db", {31'd0, BTN_DB}, 32'd0);
    checkOutput("bounce_cnt", {24'd0, PRESS_CNT}, 32'd0);

    // Three bounces, then stable high.
    doReset();
    rises0 = intrRises;
    for (int b = 0; b < 3; b++) begin
      applyStimulus(1'b1, 2);
      applyStimulus(1'b0, 2);
    end
    applyStimulus(1'b1, 5);
    checkOutput("bounced_intr_e5", {31'd0, INTR}, 32'd0);
    tick(1);
    checkOutput("bounced_intr_e6", {31'd0, INTR}, 32'd1);
    tick(2);
    checkOutput("bounced_intr_e8", {31'd0, INTR}, 32'd1);
    tick(1);
    checkOutput("bounced_intr_e9", {31'd0, INTR}, 32'd0);
    tick(20);
    checkOutput("bounced_rises", intrRises - rises0, 32'd1);
    checkOutput("bounced_cnt", {24'd0, PRESS_CNT}, 32'd1);

    // Short press: BTN drops after edge 7; HELD entered at edge 9, BTN_DB falls at edge 13.
    doReset();
    applyStimulus(1'b1, 6);
    checkOutput("short_intr_e6", {31'd0, INTR}, 32'd1);
    tick(1);
    BTN = 1'b0;
    tick(1);
    checkOutput("short_intr_e8", {31'd0, INTR}, 32'd1);
    tick(1);
    checkOutput("short_intr_e9", {31'd0, INTR}, 32'd0);
    tick(3);
    checkOutput("short_db_e12", {31'd0, BTN_DB}, 32'd1);
    tick(1);
    checkOutput("short_db_e13", {31'd0, BTN_DB}, 32'd0);
    tick(4);
    applyStimulus(1'b1, 12);
    checkOutput("short_second_cnt", {24'd0, PRESS_CNT}, 32'd2);
    applyStimulus(1'b0, 10);

    // 256 clean presses wrap the 8-bit counter.
    doReset();
    rises0 = intrRises;
    for (int p = 1; p <= 256; p++) begin
      applyStimulus(1'b1, 12);
      applyStimulus(1'b0, 8);
      if (p == 255) checkOutput("wrap_cnt_255", {24'd0, PRESS_CNT}, 32'd255);
    end
    checkOutput("wrap_cnt_0", {24'd0, PRESS_CNT}, 32'd0);
    checkOutput("wrap_rises", intrRises - rises0, 32'd256);

    // Asynchronous reset one cycle into the pulse, between clock edges.
    doReset();
    applyStimulus(1'b1, 7);
    checkOutput("areset_intr_before", {31'd0, INTR}, 32'd1);
    #2;
    RST = 1'b1;
    #1;
    checkOutput("areset_intr", {31'd0, INTR}, 32'd0);
    checkOutput("areset_db", {31'd0, BTN_DB}, 32'd0);
    checkOutput("areset_cnt", {24'd0, PRESS_CNT}, 32'd0);
    tick(2);
    RST = 1'b0;
    tick(5);
    checkOutput("areset_fresh_e5", {31'd0, INTR}, 32'd0);
    tick(1);
    checkOutput("areset_fresh_e6", {31'd0, INTR}, 32'd1);
    checkOutput("areset_fresh_cnt", {24'd0, PRESS_CNT}, 32'd1);
    tick(5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
